// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline.
// Captures the decoded bundle and operands into EX, detects load-use hazards and applies EX flush.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CTRL_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flush,
  input  logic              hold,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd
);

  localparam int unsigned MEM_READ_BIT = 4;

  logic load_use;
  logic bubble;

  // $zero as the load target can never feed a stale value, so it is excluded.
  always_comb begin
    load_use = ex_valid & ex_ctrl[MEM_READ_BIT] & (ex_rt != '0) &
               ((ex_rt == id_rs) | (ex_rt == id_rt)) & id_valid;
    hazard_stall = load_use & ~flush & ~hold;
    bubble = load_use | ~id_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_pc4     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
    end else if (flush || !hold) begin
      // Flush outranks hold; bubbles still load the datapath fields, only control is zeroed.
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_pc4     <= id_pc4;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      if (flush || bubble) begin
        ex_ctrl  <= '0;
        ex_valid <= 1'b0;
      end else begin
        ex_ctrl  <= id_ctrl;
        ex_valid <= 1'b1;
      end
    end
  end

endmodule
